// File: rtl/abofs_cfg_looper_if.sv
// abofs_cfg_looper_if: packet-in / per-config-beat-out bus for abofs_cfg_looper.
// The slave modport is the looper's view; the master modport is the peer side.
interface abofs_cfg_looper_if #(
  parameter int unsigned WBW    = 32,
  parameter int unsigned VDIM   = 2,
  parameter int unsigned CFG_BW = 3
);
  typedef logic [VDIM-1:0][WBW-1:0] ofs_t;

  // upstream packet
  logic              src_rdy;
  logic              src_ack;
  ofs_t              i_bofs;
  ofs_t              i_aofs_beg;
  ofs_t              i_aofs_end;
  logic [CFG_BW-1:0] i_beg;
  logic [CFG_BW-1:0] i_end;

  // downstream beats
  logic              dst_rdy;
  logic              dst_ack;
  logic [CFG_BW-1:0] o_id;
  ofs_t              o_bofs;
  ofs_t              o_aofs_beg;
  ofs_t              o_aofs_end;
  logic              o_islast;
  logic              done_dval;

  modport slave (
    input  src_rdy, i_bofs, i_aofs_beg, i_aofs_end, i_beg, i_end, dst_ack,
    output src_ack, dst_rdy, o_id, o_bofs, o_aofs_beg, o_aofs_end, o_islast, done_dval
  );

  modport master (
    output src_rdy, i_bofs, i_aofs_beg, i_aofs_end, i_beg, i_end, dst_ack,
    input  src_ack, dst_rdy, o_id, o_bofs, o_aofs_beg, o_aofs_end, o_islast, done_dval
  );
endinterface

// File: rtl/abofs_cfg_looper.sv
// abofs_cfg_looper: takes one block packet and emits one beat per config id in
// [beg, end), repeating the packet offsets on every beat.
// Optional macro ABOFS_CFG_LOOPER_OVERLAP_EN: accept the next packet in the same
// cycle the last beat retires (zero bubble). Undefined: accept only while idle.
module abofs_cfg_looper #(
  parameter int unsigned WBW   = 32,
  parameter int unsigned VDIM  = 2,
  parameter int unsigned N_CFG = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  abofs_cfg_looper_if.slave   bus
);
  localparam int unsigned CFG_BW = $clog2(N_CFG + 1);
  localparam int unsigned CNT_W  = CFG_BW + 1;

  typedef logic [VDIM-1:0][WBW-1:0] ofs_t;
  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CFG_BW-1:0] cur_q, cur_d;
  logic [CFG_BW-1:0] end_q, end_d;
  ofs_t              bofs_q, abeg_q, aend_q;
  logic              load;
  logic              busy;
  logic              beat;
  logic              islast;
  logic              nonempty;
  logic              src_ack;
  logic              done;

  // State, id cursor and end register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
    end
  end

  // Offset copies, loaded only on a non-empty packet accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bofs_q <= '0;
      abeg_q <= '0;
      aend_q <= '0;
    end else if (load) begin
      bofs_q <= bus.i_bofs;
      abeg_q <= bus.i_aofs_beg;
      aend_q <= bus.i_aofs_end;
    end
  end

  // Next-state, handshake and retire logic
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    end_d    = end_q;
    load     = 1'b0;
    busy     = (state_q == BUSY);
    // widened compare so end == N_CFG cannot wrap
    islast   = busy && ((CNT_W'(cur_q) + CNT_W'(1)) == CNT_W'(end_q));
    beat     = busy && bus.dst_ack;
    nonempty = (bus.i_beg < bus.i_end);
`ifdef ABOFS_CFG_LOOPER_OVERLAP_EN
    src_ack  = !i_rst && bus.src_rdy && (!busy || (beat && islast));
`else
    src_ack  = !i_rst && bus.src_rdy && !busy;
`endif
    // a last beat and an empty-packet accept in one cycle merge into one pulse
    done     = !i_rst && ((beat && islast) || (src_ack && !nonempty));

    case (state_q)
      IDLE: begin
        if (src_ack && nonempty) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (beat) begin
          if (!islast) begin
            cur_d = cur_q + CFG_BW'(1);
          end else begin
            state_d = IDLE;
            if (src_ack && nonempty) begin
              load    = 1'b1;
              state_d = BUSY;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      cur_d = bus.i_beg;
      end_d = bus.i_end;
    end
  end

  assign bus.src_ack    = src_ack;
  assign bus.done_dval  = done;
  assign bus.dst_rdy    = busy;
  assign bus.o_id       = cur_q;
  assign bus.o_islast   = islast;
  assign bus.o_bofs     = bofs_q;
  assign bus.o_aofs_beg = abeg_q;
  assign bus.o_aofs_end = aend_q;
endmodule
